// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU controller: opcode set, ALU
// operation codes, PC source selects, sequencer state encoding and small
// opcode classification helpers.
package cpu_ctrl_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned ALU_W = 3;
   localparam int unsigned PCS_W = 2;

   localparam logic [OP_W-1:0] OP_JAL  = 4'b0000;
   localparam logic [OP_W-1:0] OP_JALR = 4'b0001;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'b0010;
   localparam logic [OP_W-1:0] OP_BLE  = 4'b0011;
   localparam logic [OP_W-1:0] OP_LB   = 4'b0100;
   localparam logic [OP_W-1:0] OP_LW   = 4'b0101;
   localparam logic [OP_W-1:0] OP_SB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_SW   = 4'b0111;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b1001;
   localparam logic [OP_W-1:0] OP_AND  = 4'b1010;
   localparam logic [OP_W-1:0] OP_OR   = 4'b1011;
   localparam logic [OP_W-1:0] OP_ADDI = 4'b1100;
   localparam logic [OP_W-1:0] OP_SUBI = 4'b1101;
   localparam logic [OP_W-1:0] OP_ANDI = 4'b1110;
   localparam logic [OP_W-1:0] OP_ORI  = 4'b1111;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
   localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
   localparam logic [ALU_W-1:0] ALU_BEQ = 3'd4;
   localparam logic [ALU_W-1:0] ALU_BLE = 3'd5;

   localparam logic [PCS_W-1:0] PC_INC = 2'd0;  // PC+2
   localparam logic [PCS_W-1:0] PC_REL = 2'd1;  // PC+imm
   localparam logic [PCS_W-1:0] PC_REG = 2'd2;  // rs1+imm

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   function automatic logic is_branch(input logic [OP_W-1:0] op);
      return op[3:1] == 3'b001;
   endfunction

   function automatic logic is_mem(input logic [OP_W-1:0] op);
      return op[3:2] == 2'b01;
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return is_mem(op) && op[1];
   endfunction

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return is_mem(op) && !op[1];
   endfunction

   // lw/sw move a halfword, lb/sb a byte
   function automatic logic is_half(input logic [OP_W-1:0] op);
      return op[0];
   endfunction

   // Register and immediate ALU ops share the low two opcode bits
   function automatic logic [ALU_W-1:0] alu_of(input logic [OP_W-1:0] op);
      case (op[1:0])
         2'd0:    return ALU_ADD;
         2'd1:    return ALU_SUB;
         2'd2:    return ALU_AND;
         default: return ALU_OR;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// master: the controller (drives strobes/selects, receives op/zero/readies)
// slave : the datapath and memories side
interface multicycle_ctrl_if;
   import cpu_ctrl_pkg::*;

   logic [OP_W-1:0]  op;
   logic             zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             dmem_req;
   logic             ir_we;
   logic             pc_we;
   logic [PCS_W-1:0] PCsrc;
   logic [ALU_W-1:0] ALUOp;
   logic             alucsrc;
   logic             wmem;
   logic             memc;
   logic             m2reg;
   logic             wreg;
   logic             jal;
   logic             instr_done;
   logic             halted;
   logic             err;

   modport master (
      input  op, zero, imem_ready, dmem_ready,
      output imem_req, dmem_req, ir_we, pc_we, PCsrc, ALUOp, alucsrc,
             wmem, memc, m2reg, wreg, jal, instr_done, halted, err
   );

   modport slave (
      output op, zero, imem_ready, dmem_ready,
      input  imem_req, dmem_req, ir_we, pc_we, PCsrc, ALUOp, alucsrc,
             wmem, memc, m2reg, wreg, jal, instr_done, halted, err
   );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter shared by the fetch and data-memory phases.
// clear  : zero the count (state transition)
// enable : count one wait cycle, saturating at LIMIT
// count  : current wait cycles
// expired: count has reached LIMIT
module mc_wait_timer #(
   parameter int unsigned LIMIT = 15,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count,
   output logic             expired
);

   assign expired = (count == CNT_W'(LIMIT));

   // Saturating wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 16-bit CPU: FETCH/DECODE/EXEC/MEM/WB with
// stalling memory handshakes and a sticky timeout halt.
// clk, rst : clock, asynchronous active-high reset
// bus      : master side of multicycle_ctrl_if (op/zero/readies in,
//            datapath strobes/selects, instr_done, halted, err out)
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   multicycle_ctrl_if.master bus
);

   state_t          state, state_next;
   logic [OP_W-1:0] op_q;
   logic            err_q;
   logic            wait_clr, wait_en, wait_exp;
   logic [CNT_W-1:0] wait_cnt;

   mc_wait_timer #(.LIMIT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (wait_clr),
      .enable  (wait_en),
      .count   (wait_cnt),
      .expired (wait_exp)
   );

   always_comb assert (wait_cnt <= CNT_W'(TIMEOUT));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_FETCH;
      else     state <= state_next;
   end

   // Opcode latch and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == ST_DECODE) op_q <= bus.op;
         if (state_next == ST_HALT) err_q <= 1'b1;
      end
   end

   // Wait counting only while stalled on the memory owned by this phase
   always_comb begin
      wait_en  = ((state == ST_FETCH) && !bus.imem_ready) ||
                 ((state == ST_MEM)   && !bus.dmem_ready);
      wait_clr = (state_next != state);
   end

   // Next-state logic; a ready in the expiry cycle still wins
   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH:  if (bus.imem_ready) state_next = ST_DECODE;
                    else if (wait_exp)  state_next = ST_HALT;
         ST_DECODE: state_next = ST_EXEC;
         ST_EXEC:   if (is_branch(op_q))   state_next = ST_FETCH;
                    else if (is_mem(op_q)) state_next = ST_MEM;
                    else                   state_next = ST_WB;
         ST_MEM:    if (bus.dmem_ready) state_next = is_store(op_q) ? ST_FETCH : ST_WB;
                    else if (wait_exp)  state_next = ST_HALT;
         ST_WB:     state_next = ST_FETCH;
         ST_HALT:   state_next = ST_HALT;
         default:   state_next = ST_FETCH;
      endcase
   end

   // Output decode; everything forced low while in reset
   always_comb begin
      bus.imem_req   = 1'b0;
      bus.dmem_req   = 1'b0;
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.PCsrc      = PC_INC;
      bus.ALUOp      = ALU_ADD;
      bus.alucsrc    = 1'b0;
      bus.wmem       = 1'b0;
      bus.memc       = 1'b0;
      bus.m2reg      = 1'b0;
      bus.wreg       = 1'b0;
      bus.jal        = 1'b0;
      bus.instr_done = 1'b0;
      bus.halted     = 1'b0;
      bus.err        = err_q;
      if (!rst) begin
         case (state)
            ST_FETCH: begin
               bus.imem_req = 1'b1;
               bus.ir_we    = bus.imem_ready;
            end
            ST_EXEC: begin
               case (op_q)
                  OP_ADD, OP_SUB, OP_AND, OP_OR:
                     bus.ALUOp = alu_of(op_q);
                  OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                     bus.ALUOp   = alu_of(op_q);
                     bus.alucsrc = 1'b1;
                  end
                  OP_LB, OP_LW, OP_SB, OP_SW:
                     bus.alucsrc = 1'b1;
                  OP_BEQ, OP_BLE: begin
                     bus.ALUOp      = (op_q == OP_BEQ) ? ALU_BEQ : ALU_BLE;
                     bus.pc_we      = 1'b1;
                     bus.PCsrc      = bus.zero ? PC_INC : PC_REL;
                     bus.instr_done = 1'b1;
                  end
                  OP_JAL:  bus.ALUOp = ALU_ADD;
                  OP_JALR: bus.alucsrc = 1'b1;
                  default: ;
               endcase
            end
            ST_MEM: begin
               bus.dmem_req = 1'b1;
               bus.alucsrc  = 1'b1;
               bus.wmem     = is_store(op_q);
               bus.memc     = is_half(op_q);
               if (bus.dmem_ready && is_store(op_q)) begin
                  bus.pc_we      = 1'b1;
                  bus.instr_done = 1'b1;
               end
            end
            ST_WB: begin
               bus.wreg       = 1'b1;
               bus.pc_we      = 1'b1;
               bus.instr_done = 1'b1;
               if (is_load(op_q)) begin
                  bus.m2reg = 1'b1;
                  bus.memc  = is_half(op_q);
               end
               if (op_q == OP_JAL) begin
                  bus.jal   = 1'b1;
                  bus.PCsrc = PC_REL;
               end
               if (op_q == OP_JALR) begin
                  bus.jal     = 1'b1;
                  bus.PCsrc   = PC_REG;
                  bus.alucsrc = 1'b1;
               end
            end
            ST_HALT: begin
               bus.halted = 1'b1;
               bus.err    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction
// behavioural model (latency, strobe counts, retire-cycle selects).
module tb_multicycle_ctrl;
   import cpu_ctrl_pkg::*;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int outs();
      return int'({bus.imem_req, bus.dmem_req, bus.ir_we, bus.pc_we, bus.PCsrc,
                   bus.ALUOp, bus.alucsrc, bus.wmem, bus.memc, bus.m2reg,
                   bus.wreg, bus.jal, bus.instr_done, bus.halted, bus.err});
   endfunction

   // Reference rules, per opcode
   function automatic int f_mem(input logic [3:0] o);   return int'(o >= OP_LB && o <= OP_SW); endfunction
   function automatic int f_store(input logic [3:0] o); return int'(o == OP_SB || o == OP_SW); endfunction
   function automatic int f_load(input logic [3:0] o);  return int'(o == OP_LB || o == OP_LW); endfunction
   function automatic int f_br(input logic [3:0] o);    return int'(o == OP_BEQ || o == OP_BLE); endfunction

   function automatic int exp_lat(input logic [3:0] o, input int wi, input int wd);
      if (f_br(o) != 0)    return 3 + wi;
      if (f_store(o) != 0) return 4 + wi + wd;
      if (f_load(o) != 0)  return 5 + wi + wd;
      return 4 + wi;
   endfunction

   function automatic int exp_alu(input logic [3:0] o);
      logic [3:0] v;
      v = o;
      if (v == OP_BEQ) return 4;
      if (v == OP_BLE) return 5;
      if (v >= OP_ADD) return int'(v[1:0]);
      return 0;
   endfunction

   function automatic int exp_csrc(input logic [3:0] o);
      return int'(o == OP_JALR || f_mem(o) != 0 || o >= OP_ADDI);
   endfunction

   function automatic int exp_pcsrc(input logic [3:0] o, input logic z);
      if (f_br(o) != 0)  return z ? 0 : 1;
      if (o == OP_JAL)   return 1;
      if (o == OP_JALR)  return 2;
      return 0;
   endfunction

   // Run one instruction with wi fetch waits and wd data waits; starts in FETCH
   task automatic run_instr(input logic [3:0] iop, input logic izero, input int wi, input int wd);
      int done_c = -1;
      int n_ireq = 0, n_irwe = 0, n_dreq = 0, n_wmem = 0, n_memc = 0;
      int n_wreg = 0, n_pcwe = 0, n_done = 0, n_halt = 0;
      int pcsrc_r = 0, m2reg_r = 0, jal_r = 0, memc_r = 0, csrc_r = 0, pcwe_r = 0;
      int alu_e = -1, csrc_e = -1;
      int mem = f_mem(iop);
      int ms = wi + 3;
      for (int c = 0; c < 20; c++) begin
         bus.imem_ready = (c < wi) ? 1'b0 : (c == wi) ? 1'b1 : 1'($urandom);
         bus.op         = (c == wi + 1) ? iop : 4'($urandom);
         bus.zero       = (c == wi + 2) ? izero : 1'($urandom);
         if (mem != 0 && c >= ms && c < ms + wd) bus.dmem_ready = 1'b0;
         else if (mem != 0 && c == ms + wd)      bus.dmem_ready = 1'b1;
         else                                    bus.dmem_ready = 1'($urandom);
         @(negedge clk);
         n_ireq += int'(bus.imem_req);
         n_irwe += int'(bus.ir_we);
         n_dreq += int'(bus.dmem_req);
         n_wmem += int'(bus.dmem_req & bus.wmem);
         n_memc += int'(bus.dmem_req & bus.memc);
         n_wreg += int'(bus.wreg);
         n_pcwe += int'(bus.pc_we);
         n_done += int'(bus.instr_done);
         n_halt += int'(bus.halted | bus.err);
         if (c == wi + 2) begin
            alu_e  = int'(bus.ALUOp);
            csrc_e = int'(bus.alucsrc);
         end
         if (bus.instr_done) begin
            done_c  = c;
            pcsrc_r = int'(bus.PCsrc);
            m2reg_r = int'(bus.m2reg);
            jal_r   = int'(bus.jal);
            memc_r  = int'(bus.memc);
            csrc_r  = int'(bus.alucsrc);
            pcwe_r  = int'(bus.pc_we);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("retired", int'(done_c >= 0), 1);
      if (done_c < 0) return;
      chk("latency", done_c + 1, exp_lat(iop, wi, wd));
      chk("done_cnt", n_done, 1);
      chk("pcwe_at_done", pcwe_r, 1);
      chk("pcwe_cnt", n_pcwe, 1);
      chk("imem_req_cyc", n_ireq, wi + 1);
      chk("ir_we_cnt", n_irwe, 1);
      chk("dmem_req_cyc", n_dreq, (mem != 0) ? wd + 1 : 0);
      chk("wmem_cyc", n_wmem, (f_store(iop) != 0) ? wd + 1 : 0);
      chk("memc_cyc", n_memc, (mem != 0 && iop[0]) ? wd + 1 : 0);
      chk("wreg_cnt", n_wreg, (f_br(iop) == 0 && f_store(iop) == 0) ? 1 : 0);
      chk("pcsrc", pcsrc_r, exp_pcsrc(iop, izero));
      chk("m2reg", m2reg_r, f_load(iop));
      chk("jal", jal_r, int'(iop == OP_JAL || iop == OP_JALR));
      chk("memc_ret", memc_r, int'(mem != 0 && iop[0]));
      chk("alucsrc_ret", csrc_r, int'(iop == OP_JALR || f_store(iop) != 0));
      chk("alu_exec", alu_e, exp_alu(iop));
      chk("csrc_exec", csrc_e, exp_csrc(iop));
      chk("no_halt", n_halt, 0);
   endtask

   initial begin
      int first_h, err_at, n_h, n_str;
      bus.op = '0; bus.zero = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;

      // Reset state
      bus.imem_ready = 1'b1;
      @(negedge clk);
      chk("reset_outs", outs(), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed cases, then boundary waits, then random mix
      run_instr(OP_ADD, 1'b0, 0, 0);
      run_instr(OP_LW, 1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b0, 0, 0);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_JALR, 1'b0, 1, 0);
      run_instr(OP_JAL, 1'b0, 0, 0);
      run_instr(OP_SW, 1'b0, TO, TO);
      run_instr(OP_LB, 1'b0, TO, 0);
      run_instr(OP_BLE, 1'b0, 2, 0);
      for (int i = 0; i < 80; i++)
         run_instr(4'($urandom), 1'($urandom), int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));

      // sw abandoned by reset while stalled in MEM
      bus.op = OP_SW; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.imem_ready = 1'b0;
      @(negedge clk);
      chk("sw_mem_dreq", int'(bus.dmem_req & bus.wmem & bus.memc), 1);
      chk("sw_mem_pcwe", int'(bus.pc_we | bus.wreg | bus.instr_done), 0);
      #2 rst = 1'b1;
      #1 chk("rst_async_outs", outs(), 0);
      @(posedge clk); #1;
      chk("rst_held_outs", outs(), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_fetch", int'(bus.imem_req), 1);
      chk("post_rst_strobes", int'(bus.pc_we | bus.wreg | bus.err | bus.halted), 0);
      @(posedge clk); #1;
      run_instr(OP_ADD, 1'b0, 0, 0);

      // Fetch timeout
      bus.imem_ready = 1'b0;
      first_h = -1; err_at = 0;
      for (int c = 0; c < int'(TO) + 4; c++) begin
         bus.op = 4'($urandom); bus.zero = 1'($urandom); bus.dmem_ready = 1'($urandom);
         @(negedge clk);
         if (bus.halted && first_h < 0) begin
            first_h = c;
            err_at  = int'(bus.err);
         end
         @(posedge clk); #1;
      end
      chk("halt_cycle", first_h, int'(TO) + 1);
      chk("err_at_halt", err_at, 1);
      bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
      n_h = 0; n_str = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_h   += int'(bus.halted & bus.err);
         n_str += int'(bus.imem_req | bus.ir_we | bus.pc_we | bus.wreg | bus.dmem_req | bus.instr_done);
         @(posedge clk); #1;
      end
      chk("halt_sticky", n_h, 6);
      chk("halt_strobes", n_str, 0);
      rst = 1'b1;
      #1 chk("halt_rst_outs", outs(), 0);
      @(posedge clk); #1;
      rst = 1'b0; bus.imem_ready = 1'b0;
      @(negedge clk);
      chk("halt_rst_fetch", int'(bus.imem_req), 1);
      chk("halt_rst_err", int'(bus.err | bus.halted), 0);
      @(posedge clk); #1;
      run_instr(OP_ORI, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
